// File: rtl/mac8_pkg.sv
// rtl/mac8_pkg.sv - shared mac8 writeback types and constants
package mac8_pkg;

    localparam int MAC8_PIPE_LAT      = 3;
    localparam int MAC8_WB_DEPTH      = 4;
    localparam int MAC8_XLEN          = 32;
    localparam int MAC8_TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [MAC8_XLEN-1:0]          data;
        logic [MAC8_TRANS_ID_BITS-1:0] trans_id;
    } mac8_wb_entry_t;

endpackage

// File: rtl/mac8_credit_ctr.sv
// rtl/mac8_credit_ctr.sv - mac8 in-flight counter and issue credit
module mac8_credit_ctr
    import mac8_pkg::*;
#(
    parameter int DEPTH    = MAC8_WB_DEPTH,
    parameter int PIPE_LAT = MAC8_PIPE_LAT,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          issue_valid_i,
    input  logic          res_valid_i,
    input  logic [CW-1:0] count_i,
    output logic          issue_ready_o
);

    localparam int IW = $clog2(PIPE_LAT + 1);
    localparam logic [IW-1:0] INFLIGHT_MAX = IW'(PIPE_LAT);

    logic [IW-1:0] inflight_q;
    logic [CW:0]   used;
    logic          issue_fire;

    // Every issued op owns a FIFO slot until it is popped, so a result can never hit a full FIFO.
    assign used          = {1'b0, count_i} + (CW + 1)'(inflight_q);
    assign issue_ready_o = (used < (CW + 1)'(DEPTH)) && !rst_i;
    assign issue_fire    = issue_valid_i && issue_ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            inflight_q <= '0;
        end else if (issue_fire && !res_valid_i) begin
            if (inflight_q != INFLIGHT_MAX) begin
                inflight_q <= inflight_q + 1'b1;
            end
        end else if (!issue_fire && res_valid_i) begin
            if (inflight_q != '0) begin
                inflight_q <= inflight_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac8_wb_buffer.sv
// rtl/mac8_wb_buffer.sv - mac8 result FIFO and writeback adapter; MAC8_WB_BYPASS_EN enables empty-FIFO bypass
module mac8_wb_buffer
    import mac8_pkg::*;
#(
    parameter int DEPTH         = MAC8_WB_DEPTH,
    parameter int PIPE_LAT      = MAC8_PIPE_LAT,
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic                       res_valid_i,
    input  logic [XLEN-1:0]            res_data_i,
    input  logic [TRANS_ID_BITS-1:0]   res_trans_id_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [XLEN-1:0]            wb_data_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic                       overflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0]          data;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head_q;
    entry_t          head_d;
    entry_t          res_entry;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_next;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic            has_entry;
    logic            full;
    logic            bypass_hit;
    logic            push;
    logic            push_ok;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign res_entry = '{data: res_data_i, trans_id: res_trans_id_i};
    assign has_entry = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));

`ifdef MAC8_WB_BYPASS_EN
    assign bypass_hit = !has_entry && res_valid_i && !flush_i;
`else
    assign bypass_hit = 1'b0;
`endif

    assign wb_valid_o    = has_entry || bypass_hit;
    assign wb_data_o     = bypass_hit ? res_data_i : head_q.data;
    assign wb_trans_id_o = bypass_hit ? res_trans_id_i : head_q.trans_id;
    assign occupancy_o   = count_q;
    assign overflow_o    = overflow_q;

    assign pop     = has_entry && wb_ready_i && !flush_i;
    assign push    = res_valid_i && !flush_i && !(bypass_hit && wb_ready_i);
    assign push_ok = push && (!full || pop);
    assign rd_next = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // The head is registered so the writeback outputs never depend on the RAM read path.
    always_comb begin
        head_d = head_q;
        if (pop && count_q > CW'(1)) begin
            head_d = mem_q[rd_next];
        end else if ((push_ok || bypass_hit) &&
                     (count_q == '0 || (pop && count_q == CW'(1)))) begin
            head_d = res_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= res_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            head_q   <= head_d;
            rd_ptr_q <= rd_next;
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    mac8_credit_ctr #(
        .DEPTH    (DEPTH),
        .PIPE_LAT (PIPE_LAT),
        .CW       (CW)
    ) u_credit (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .res_valid_i   (res_valid_i),
        .count_i       (count_q),
        .issue_ready_o (issue_ready_o)
    );

endmodule
